envelope_generator: RTL
=======================

// Module: envelope_generator
// PURPOSE
//  ADSR envelope generator that produces the Amplitude word consumed by the Amplifier.
//  Runs at the sample-rate strobe: one envelope step per Env_ce cycle.
//  The gate comes from the note/key logic. The output is a zero-extended 16-bit level, range 0..0x7FFF.
// PARAMETERS
//  LEVEL_W    16       envelope level / step width, bits
//  LEVEL_MAX  16'h7FFF full-scale level; attack clamps here
// PORTS
//  Sys_clk       in   1   system clock; all logic on rising edge
//  Env_rst       in   1   synchronous, active-high reset
//  Env_ce        in   1   sample strobe; state/level update only when 1
//  Gate          in   1   note on (1) / note off (0), sampled on Env_ce cycles
//  Attack_step   in   16  increment per ce in ATTACK; 0 = jump to LEVEL_MAX
//  Decay_step    in   16  decrement per ce in DECAY; 0 = jump to sustain
//  Sustain_level in   16  sustain target; values > LEVEL_MAX treated as LEVEL_MAX
//  Release_step  in   16  decrement per ce in RELEASE; 0 = jump to 0
//  Envelope      out  32  {16'h0, level}; connects to Amplifier Amplitude
//  Env_state     out  3   IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//  Env_active    out  1   1 when Env_state != IDLE
// BEHAVIOUR
//  - Reset:
//    - Env_rst=1 wins over Env_ce.
//    - Next edge: state=IDLE, level=0, gate_q=0, Envelope=0, Env_state=0, Env_active=0.
//    - Mid-note reset aborts immediately, with no release.
//  - All outputs are registered.
//    - An update computed on a ce edge is visible after that edge (latency 1 clk).
//  - Env_ce=0: state, level and gate_q hold.
//    - Gate pulses that start and end between ce cycles are ignored.
//  - gate_q <= Gate on every ce cycle. rise = Gate & ~gate_q.
//  - Per-ce priority:
//    1. rise: state<=ATTACK and an attack step is applied this cycle.
//       - Retrigger from any state starts from the current level (no reset to 0).
//    2. Gate=0 in ATTACK/DECAY/SUSTAIN: state<=RELEASE and a release step is applied this cycle.
//    3. Otherwise the step of the current state is applied.
//  - Step arithmetic is 17-bit unsigned, so there is no wrap-around:
//    - ATTACK:
//      - n = level + Attack_step.
//      - If n >= LEVEL_MAX or the step is 0: level=LEVEL_MAX, ->DECAY.
//      - Else level=n.
//    - DECAY:
//      - n = level - Decay_step.
//      - If n <= S (signed) or the step is 0: level=S, ->SUSTAIN.
//      - Else level=n.
//      - S = min(Sustain_level, LEVEL_MAX).
//    - SUSTAIN: level=S every ce; Sustain_level changes are tracked live.
//    - RELEASE:
//      - n = level - Release_step.
//      - If n <= 0 or the step is 0: level=0, ->IDLE.
//      - Else level=n.
//    - IDLE: level=0. Gate=0 keeps IDLE.
//  - Gate held high through a reset: the first ce after reset sees rise=1 and starts ATTACK.
// TESTING
//  1. Reset:
//     - Stimulus: Gate=1, Env_ce=1, mid-ATTACK, pulse Env_rst for 1 clk.
//     - Response: Envelope=0, Env_state=0, Env_active=0. The next ce restarts ATTACK at Attack_step.
//  2. Attack:
//     - Stimulus: Attack_step=0x1000, Gate 0->1.
//     - Response: successive ce give Envelope 0x1000..0x7000, then 0x7FFF on the 8th ce with Env_state=2.
//  3. Decay:
//     - Stimulus: Decay_step=0x1800, Sustain=0x4000, from 0x7FFF.
//     - Response: 0x67FF, 0x4FFF, then 0x4000 with Env_state=3. Changing Sustain to 0x3000 gives 0x3000 on the next ce.
//  4. Release:
//     - Stimulus: Gate 1->0 at 0x4000, Release_step=0x3000.
//     - Response: 0x1000 (state 4), then 0x0000 (state 0, Env_active=0).
//  5. Retrigger:
//     - Stimulus: Gate rises while in RELEASE at level 0x1000, Attack_step=0x1000.
//     - Response: Envelope=0x2000, Env_state=1 on that ce.
//  6. Ce gating and zero steps:
//     - Stimulus A: hold Env_ce=0 for 10 clks mid-attack. Response: Envelope constant.
//     - Stimulus B: Attack_step=0. Response: 0x7FFF on the first ce.
//     - Stimulus C: Release_step=0. Response: 0 on the first gate-low ce.

Source files
------------

// File: rtl/envelope_generator.sv
// rtl/envelope_generator.sv - ADSR envelope generator stepped once per sample strobe.
// Level and state are registered. All outputs are decoded directly from those registers.
module envelope_generator #(
  parameter int                 LEVEL_W   = 16,
  parameter logic [LEVEL_W-1:0] LEVEL_MAX = 16'h7FFF
) (
  input  logic               Sys_clk,
  input  logic               Env_rst,
  input  logic               Env_ce,
  input  logic               Gate,
  input  logic [LEVEL_W-1:0] Attack_step,
  input  logic [LEVEL_W-1:0] Decay_step,
  input  logic [LEVEL_W-1:0] Sustain_level,
  input  logic [LEVEL_W-1:0] Release_step,
  output logic [31:0]        Envelope,
  output logic [2:0]         Env_state,
  output logic               Env_active
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t             r_state;
  logic [LEVEL_W-1:0] r_level;
  logic               r_gate_q;

  state_t             w_eff_state;
  state_t             w_next_state;
  logic [LEVEL_W-1:0] w_next_level;
  logic [LEVEL_W-1:0] w_sus;
  logic [LEVEL_W:0]   w_attack_sum;
  logic [LEVEL_W:0]   w_decay_floor;
  logic               w_rise;

  always_ff @(posedge Sys_clk) begin
    if (Env_rst) begin
      r_state  <= IDLE;
      r_level  <= '0;
      r_gate_q <= 1'b0;
    end else if (Env_ce) begin
      r_state  <= w_next_state;
      r_level  <= w_next_level;
      r_gate_q <= Gate;
    end
  end

  always_comb begin
    w_sus         = (Sustain_level > LEVEL_MAX) ? LEVEL_MAX : Sustain_level;
    w_rise        = Gate & ~r_gate_q;
    w_attack_sum  = {1'b0, r_level} + {1'b0, Attack_step};
    // level - step <= S rearranged as level <= step + S so nothing goes negative
    w_decay_floor = {1'b0, Decay_step} + {1'b0, w_sus};

    w_eff_state = r_state;
    if (w_rise) begin
      w_eff_state = ATTACK;
    end else if (!Gate && (r_state == ATTACK || r_state == DECAY || r_state == SUSTAIN)) begin
      w_eff_state = RELEASE;
    end

    w_next_state = w_eff_state;
    w_next_level = r_level;
    case (w_eff_state)
      ATTACK: begin
        if (Attack_step == '0 || w_attack_sum >= {1'b0, LEVEL_MAX}) begin
          w_next_level = LEVEL_MAX;
          w_next_state = DECAY;
        end else begin
          w_next_level = w_attack_sum[LEVEL_W-1:0];
        end
      end
      DECAY: begin
        if (Decay_step == '0 || {1'b0, r_level} <= w_decay_floor) begin
          w_next_level = w_sus;
          w_next_state = SUSTAIN;
        end else begin
          w_next_level = r_level - Decay_step;
        end
      end
      SUSTAIN: w_next_level = w_sus;
      RELEASE: begin
        if (Release_step == '0 || r_level <= Release_step) begin
          w_next_level = '0;
          w_next_state = IDLE;
        end else begin
          w_next_level = r_level - Release_step;
        end
      end
      default: begin
        w_next_level = '0;
        w_next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    Envelope   = {{(32-LEVEL_W){1'b0}}, r_level};
    Env_state  = r_state;
    Env_active = (r_state != IDLE);
  end

endmodule
